// File: rtl/pc_sequencer_if.sv
// Front-end redirect/fetch bundle between the core and the PC sequencer.
// The sequencer uses the slave modport; the core-side driver uses master.
interface pc_sequencer_if;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        br_valid;
  logic [31:0] br_target;
  logic        stall;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        flush;
  logic        misaligned;
  logic [15:0] redirect_count;

  modport master (
    output trap_valid, trap_vector, jmp_valid, jmp_target, br_valid, br_target,
           stall, if_ready,
    input  if_valid, if_pc, flush, misaligned, redirect_count
  );

  modport slave (
    input  trap_valid, trap_vector, jmp_valid, jmp_target, br_valid, br_target,
           stall, if_ready,
    output if_valid, if_pc, flush, misaligned, redirect_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC owner: arbitrates trap > jump > branch redirects, drives the fetch
// handshake, and runs a counted flush window after each accepted redirect.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  localparam logic [2:0] DEPTH = 3'(FLUSH_DEPTH);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic        mis_q, mis_d;

  logic        any_req;
  logic        accept;
  logic        fetch_fire;
  logic        if_valid;
  logic [31:0] sel_target;
  logic [31:0] clr_target;
  logic [31:0] fin_target;

  assign if_valid   = (state_q != BOOT) && !bus.stall;
  assign fetch_fire = if_valid && bus.if_ready;
  assign any_req    = bus.trap_valid || bus.jmp_valid || bus.br_valid;

  // Inside the flush window only traps may redirect; younger jumps/branches are squashed.
  assign accept = ((state_q == RUN) && any_req) ||
                  ((state_q == FLUSH) && bus.trap_valid);

  always_comb begin
    sel_target = bus.br_target;
    if (bus.trap_valid) begin
      sel_target = bus.trap_vector;
    end else if (bus.jmp_valid) begin
      sel_target = bus.jmp_target;
    end
  end

  assign clr_target = sel_target & ~32'h1;
  assign fin_target = clr_target[1] ? TRAP_VEC : clr_target;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    rcnt_d  = rcnt_q;
    mis_d   = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (accept) begin
          state_d = FLUSH;
          cnt_d   = DEPTH;
        end
      end
      FLUSH: begin
        if (accept) begin
          cnt_d = DEPTH;
        end else if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = BOOT;
    endcase

    // A redirect wins over both stall and a same-cycle fetch handshake.
    if (accept) begin
      pc_d  = fin_target;
      mis_d = clr_target[1];
      if (rcnt_q != 16'hFFFF) begin
        rcnt_d = rcnt_q + 16'd1;
      end
    end else if (fetch_fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= BOOT;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC;
      rcnt_q  <= 16'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      rcnt_q  <= rcnt_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.if_valid       = if_valid;
  assign bus.if_pc          = pc_q;
  assign bus.flush          = (state_q == FLUSH);
  assign bus.misaligned     = mis_q;
  assign bus.redirect_count = rcnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer plus hand-written sequences for
// redirect-count saturation and asynchronous reset in the middle of a flush.
module tb_pc_sequencer;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .TRAP_VEC   (32'h0000_0100),
    .FLUSH_DEPTH(2)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        tv;
    logic [31:0] tvec;
    logic        jv;
    logic [31:0] jt;
    logic        bv;
    logic [31:0] bt;
    logic        st;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_pc;
    logic        e_fl;
    logic        e_mis;
    logic [15:0] e_rc;
  } row_t;

  localparam int NROWS = 23;
  row_t vec [NROWS];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic vld, input logic [31:0] pc,
                           input logic fl, input logic mis, input logic [15:0] rc);
    check({tag, ".if_valid"},   {31'd0, bus.if_valid},     {31'd0, vld});
    check({tag, ".if_pc"},      bus.if_pc,                 pc);
    check({tag, ".flush"},      {31'd0, bus.flush},        {31'd0, fl});
    check({tag, ".misaligned"}, {31'd0, bus.misaligned},   {31'd0, mis});
    check({tag, ".rcount"},     {16'd0, bus.redirect_count}, {16'd0, rc});
  endtask

  function automatic row_t mk(input logic tv, input logic [31:0] tvec,
                              input logic jv, input logic [31:0] jt,
                              input logic bv, input logic [31:0] bt,
                              input logic st, input logic rdy,
                              input logic e_vld, input logic [31:0] e_pc,
                              input logic e_fl, input logic e_mis, input logic [15:0] e_rc);
    row_t r;
    r.tv = tv; r.tvec = tvec; r.jv = jv; r.jt = jt; r.bv = bv; r.bt = bt;
    r.st = st; r.rdy = rdy;
    r.e_vld = e_vld; r.e_pc = e_pc; r.e_fl = e_fl; r.e_mis = e_mis; r.e_rc = e_rc;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.trap_valid  = 1'b0; bus.trap_vector = 32'h0;
    bus.jmp_valid   = 1'b0; bus.jmp_target  = 32'h0;
    bus.br_valid    = 1'b0; bus.br_target   = 32'h0;
    bus.stall       = 1'b0; bus.if_ready    = 1'b1;
  endtask

  initial begin
    // Each row: inputs held for one cycle; expectations are the outputs seen in that same cycle.
    //          tv tvec          jv jt            bv bt            st rdy  vld pc            fl mis rc
    vec[0]  = mk(0, 32'h0,        1, 32'h500,      0, 32'h0,        0, 1,   0, 32'h0,        0, 0, 16'd0); // BOOT ignores jump
    vec[1]  = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h0,        0, 0, 16'd0);
    vec[2]  = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h4,        0, 0, 16'd0);
    vec[3]  = mk(0, 32'h0,        1, 32'h200,      0, 32'h0,        0, 1,   1, 32'h8,        0, 0, 16'd0);
    vec[4]  = mk(0, 32'h0,        0, 32'h0,        1, 32'h400,      0, 1,   1, 32'h200,      1, 0, 16'd1); // branch dropped
    vec[5]  = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h204,      1, 0, 16'd1);
    vec[6]  = mk(1, 32'h80,       1, 32'h200,      1, 32'h300,      0, 1,   1, 32'h208,      0, 0, 16'd1);
    vec[7]  = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h80,       1, 0, 16'd2);
    vec[8]  = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h84,       1, 0, 16'd2);
    vec[9]  = mk(0, 32'h0,        1, 32'h203,      0, 32'h0,        0, 1,   1, 32'h88,       0, 0, 16'd2);
    vec[10] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h100,      1, 1, 16'd3); // misaligned
    vec[11] = mk(1, 32'h40,       0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h104,      1, 0, 16'd3); // trap in flush
    vec[12] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h40,       1, 0, 16'd4);
    vec[13] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h44,       1, 0, 16'd4);
    vec[14] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 1,   0, 32'h48,       0, 0, 16'd4); // stall
    vec[15] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0,   0, 32'h48,       0, 0, 16'd4);
    vec[16] = mk(0, 32'h0,        0, 32'h0,        1, 32'h300,      1, 1,   0, 32'h48,       0, 0, 16'd4); // branch under stall
    vec[17] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0,   1, 32'h300,      1, 0, 16'd5);
    vec[18] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h300,      1, 0, 16'd5);
    vec[19] = mk(1, 32'hFFFF_FFFD, 0, 32'h0,       0, 32'h0,        0, 1,   1, 32'h304,      0, 0, 16'd5);
    vec[20] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'hFFFF_FFFC, 1, 0, 16'd6);
    vec[21] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h0,        1, 0, 16'd6); // wrapped
    vec[22] = mk(0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1,   1, 32'h4,        0, 0, 16'd6);

    idle_inputs();
    i_rst = 1'b0;
    #23;
    check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);

    @(negedge i_clk);
    i_rst = 1'b1;
    for (int k = 0; k < NROWS; k++) begin
      bus.trap_valid  = vec[k].tv; bus.trap_vector = vec[k].tvec;
      bus.jmp_valid   = vec[k].jv; bus.jmp_target  = vec[k].jt;
      bus.br_valid    = vec[k].bv; bus.br_target   = vec[k].bt;
      bus.stall       = vec[k].st; bus.if_ready    = vec[k].rdy;
      #1;
      check_all($sformatf("row%0d", k), vec[k].e_vld, vec[k].e_pc, vec[k].e_fl,
                vec[k].e_mis, vec[k].e_rc);
      @(negedge i_clk);
    end

    // Back-to-back traps inside flush: one accepted every cycle, count must saturate.
    idle_inputs();
    bus.trap_valid  = 1'b1;
    bus.trap_vector = 32'h10;
    repeat (65540) @(negedge i_clk);
    #1;
    check_all("sat", 1'b1, 32'h10, 1'b1, 1'b0, 16'hFFFF);
    @(negedge i_clk);
    idle_inputs();
    repeat (3) @(negedge i_clk);
    #1;
    check("sat_exit.flush", {31'd0, bus.flush}, 32'd0);
    check("sat_exit.rcount", {16'd0, bus.redirect_count}, 32'h0000_FFFF);

    // Asynchronous reset in the middle of a flush window.
    @(negedge i_clk);
    bus.jmp_valid  = 1'b1;
    bus.jmp_target = 32'h200;
    @(negedge i_clk);
    idle_inputs();
    #1;
    check("pre_rst.flush", {31'd0, bus.flush}, 32'd1);
    #1;
    i_rst = 1'b0;
    #1;
    check_all("mid_rst", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    check_all("rerun_boot", 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
    @(negedge i_clk);
    #1;
    check_all("rerun_run", 1'b1, 32'h0, 1'b0, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
